// File: rtl/nios_system_hc595_pkg.sv
// Shared definitions for the 74HC595 serial driver.
//
// Holds the 2-bit state encoding used by the driver FSM, the default
// parallel word width and divider settings, and the divider counter width.
// Imported by nios_system_hc595_tick and nios_system_hc595_driver.
package nios_system_hc595_pkg;

  // Driver FSM states. IDLE must stay at zero so that "busy" is simply a
  // decode of a non-zero state.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  // Width of the parallel word presented by the PIO port.
  localparam int DATA_W_DEFAULT = 8;

  // System clocks per serial-clock half period (legal range 1..255).
  localparam int CLK_DIV_DEFAULT = 4;

  // Width of the half-period counter; wide enough for CLK_DIV up to 255.
  localparam int DIV_W = 8;

endpackage

// File: rtl/nios_system_hc595_tick.sv
// Half-period tick generator for the 74HC595 driver.
//
// While 'run' is high the internal counter advances once per clock and
// 'tick' is asserted on the last cycle of every CLK_DIV-cycle window, after
// which the counter restarts from zero. While 'run' is low the counter is
// held at zero, so the first window after 'run' rises is a full CLK_DIV
// cycles long.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high reset
//   run   - enables counting (driver is outside IDLE)
//   tick  - one-cycle pulse marking the end of a half period
module nios_system_hc595_tick
  import nios_system_hc595_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // The tick is decoded from registered state only ('run' comes straight
  // from the driver's state register), so it never depends on data_in.
  assign tick = run && (div_cnt == LAST);

  // Half-period counter: cleared while idle and on every tick, otherwise
  // counting up. With CLK_DIV == 1 it stays at zero and ticks every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (!run || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/nios_system_hc595_driver.sv
// Serialiser from a Nios PIO output word to an external 74HC595.
//
// Whenever the parallel word differs from the last word delivered (or a
// delivery is still owed after reset), the word is captured and shifted out
// MSB first on sr_data/sr_clk, followed by a one-half-period latch pulse on
// sr_latch. A transfer always takes 17*CLK_DIV clocks. Changes of data_in
// during a transfer are ignored until the transfer ends; the value present
// at that point is then compared again, so the final stable value is always
// delivered even if intermediate values are skipped.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous, active-high reset
//   data_in  - parallel word from the PIO out_port
//   sr_clk   - shift clock to the 74HC595 (SRCLK)
//   sr_data  - serial data to the 74HC595 (SER), MSB first
//   sr_latch - storage-register latch pulse to the 74HC595 (RCLK)
//   busy     - high while a transfer is in progress
module nios_system_hc595_driver
  import nios_system_hc595_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  output logic              sr_clk,
  output logic              sr_data,
  output logic              sr_latch,
  output logic              busy
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(DATA_W - 1);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] snapshot;
  logic [DATA_W-1:0] snapshot_next;
  logic [DATA_W-1:0] last_sent;
  logic [DATA_W-1:0] last_sent_next;
  logic              pending;
  logic              pending_next;
  logic [IDX_W-1:0]  bit_idx;
  logic [IDX_W-1:0]  bit_idx_next;
  logic [IDX_W-1:0]  bit_prev;
  logic              sr_clk_next;
  logic              sr_data_next;
  logic              sr_latch_next;
  logic              busy_next;
  logic              run;
  logic              tick;
  logic              start;

  // A transfer is owed either because reset left one pending (to put the
  // external register into a known state) or because the PIO word moved.
  assign start    = pending || (data_in != last_sent);
  assign bit_prev = bit_idx - IDX_W'(1);
  assign run      = (state != IDLE);

  nios_system_hc595_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick)
  );

  // Next-state and next-output logic. Every register holds by default and
  // only moves on a start condition in IDLE or on a divider tick elsewhere,
  // which keeps sr_data stable for a full half period on both sides of each
  // sr_clk rise.
  always_comb begin
    state_next     = state;
    snapshot_next  = snapshot;
    last_sent_next = last_sent;
    pending_next   = pending;
    bit_idx_next   = bit_idx;
    sr_clk_next    = sr_clk;
    sr_data_next   = sr_data;
    sr_latch_next  = sr_latch;

    case (state)
      IDLE: begin
        if (start) begin
          snapshot_next = data_in;
          sr_data_next  = data_in[DATA_W-1];
          bit_idx_next  = TOP_IDX;
          state_next    = SHIFT_LO;
        end
      end

      SHIFT_LO: begin
        if (tick) begin
          sr_clk_next = 1'b1;
          state_next  = SHIFT_HI;
        end
      end

      SHIFT_HI: begin
        if (tick) begin
          sr_clk_next = 1'b0;
          if (bit_idx == '0) begin
            sr_latch_next = 1'b1;
            state_next    = LATCH;
          end else begin
            bit_idx_next = bit_prev;
            sr_data_next = snapshot[bit_prev];
            state_next   = SHIFT_LO;
          end
        end
      end

      LATCH: begin
        if (tick) begin
          sr_latch_next  = 1'b0;
          sr_data_next   = 1'b0;
          last_sent_next = snapshot;
          pending_next   = 1'b0;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // State and output registers. Reset clears everything immediately,
  // including a latch pulse in flight, and re-arms 'pending' so one full
  // transfer follows release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      snapshot  <= '0;
      last_sent <= '0;
      pending   <= 1'b1;
      bit_idx   <= '0;
      sr_clk    <= 1'b0;
      sr_data   <= 1'b0;
      sr_latch  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      snapshot  <= snapshot_next;
      last_sent <= last_sent_next;
      pending   <= pending_next;
      bit_idx   <= bit_idx_next;
      sr_clk    <= sr_clk_next;
      sr_data   <= sr_data_next;
      sr_latch  <= sr_latch_next;
      busy      <= busy_next;
    end
  end

endmodule

// File: tb/tb_nios_system_hc595_driver.sv
// Directed bench for nios_system_hc595_driver.
//
// Two instances: dut0 with the default CLK_DIV of 4 and dut1 with CLK_DIV
// of 1. 'sel' chooses which instance the stimulus and capture tasks work on.
// Outputs are sampled on the falling clock edge.
module tb_nios_system_hc595_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d0;
  logic [7:0] d1;
  logic       sel;

  logic sr_clk0, sr_data0, sr_latch0, busy0;
  logic sr_clk1, sr_data1, sr_latch1, busy1;
  logic m_sr_clk, m_sr_data, m_sr_latch, m_busy;

  int checks = 0;
  int errors = 0;
  int k;

  nios_system_hc595_driver #(
    .CLK_DIV (4),
    .DATA_W  (8)
  ) dut0 (
    .clk      (clk),
    .reset    (reset),
    .data_in  (d0),
    .sr_clk   (sr_clk0),
    .sr_data  (sr_data0),
    .sr_latch (sr_latch0),
    .busy     (busy0)
  );

  nios_system_hc595_driver #(
    .CLK_DIV (1),
    .DATA_W  (8)
  ) dut1 (
    .clk      (clk),
    .reset    (reset),
    .data_in  (d1),
    .sr_clk   (sr_clk1),
    .sr_data  (sr_data1),
    .sr_latch (sr_latch1),
    .busy     (busy1)
  );

  assign m_sr_clk   = sel ? sr_clk1   : sr_clk0;
  assign m_sr_data  = sel ? sr_data1  : sr_data0;
  assign m_sr_latch = sel ? sr_latch1 : sr_latch0;
  assign m_busy     = sel ? busy1     : busy0;

  // Free-running system clock, 10 time units per period.
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives the parallel word of the selected instance.
  task automatic applyStimulus(input logic [7:0] val);
    if (sel) d1 = val;
    else     d0 = val;
  endtask

  // Waits for the selected instance to go busy, then follows the transfer
  // to its end, rebuilding the shifted word from sr_data at each sr_clk
  // rise and measuring length, latch width and sr_clk period. Up to three
  // data_in changes can be injected at given busy cycles (-1 = unused).
  task automatic captureTransfer(input string tag, input logic [7:0] exp_word,
                                 input int exp_len, input int exp_latch,
                                 input int exp_period,
                                 input int c0, input logic [7:0] v0,
                                 input int c1, input logic [7:0] v1,
                                 input int c2, input logic [7:0] v2);
    int         w;
    int         len;
    int         rises;
    int         falls;
    int         latch_len;
    int         latch_bad;
    int         period_bad;
    int         last_rise;
    logic       prev_clk;
    logic [7:0] word;
    w = 0;
    len = 0;
    rises = 0;
    falls = 0;
    latch_len = 0;
    latch_bad = 0;
    period_bad = 0;
    last_rise = -1;
    prev_clk = 1'b0;
    word = 8'h00;
    do begin
      @(negedge clk);
      w++;
    end while (!m_busy && w < 20);
    checkOutput({tag, "_start_delay"}, 32'(w), 32'd1);
    while (m_busy && len < 2000) begin
      len++;
      if (len == c0) applyStimulus(v0);
      if (len == c1) applyStimulus(v1);
      if (len == c2) applyStimulus(v2);
      if (m_sr_clk && !prev_clk) begin
        rises++;
        word = {word[6:0], m_sr_data};
        if (last_rise >= 0 && (len - last_rise) != exp_period) period_bad++;
        last_rise = len;
      end
      if (!m_sr_clk && prev_clk) falls++;
      if (m_sr_latch) begin
        latch_len++;
        if (falls != 8) latch_bad++;
      end
      prev_clk = m_sr_clk;
      @(negedge clk);
    end
    checkOutput({tag, "_length"}, 32'(len), 32'(exp_len));
    checkOutput({tag, "_word"}, 32'(word), 32'(exp_word));
    checkOutput({tag, "_rises"}, 32'(rises), 32'd8);
    checkOutput({tag, "_latch_len"}, 32'(latch_len), 32'(exp_latch));
    checkOutput({tag, "_latch_early"}, 32'(latch_bad), 32'd0);
    checkOutput({tag, "_period"}, 32'(period_bad), 32'd0);
    checkOutput({tag, "_end_outputs"}, 32'({m_sr_clk, m_sr_data, m_sr_latch}), 32'd0);
  endtask

  // Confirms the selected instance stays completely quiet for n cycles.
  task automatic quietCheck(input string tag, input int n);
    int activity;
    activity = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (m_busy || m_sr_clk || m_sr_data || m_sr_latch) activity++;
    end
    checkOutput(tag, 32'(activity), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    d0 = 8'h00;
    d1 = 8'h00;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset_outputs_div4", 32'({sr_clk0, sr_data0, sr_latch0, busy0}), 32'd0);
    checkOutput("reset_outputs_div1", 32'({sr_clk1, sr_data1, sr_latch1, busy1}), 32'd0);
    checkOutput("reset_pending", 32'(dut0.pending), 32'd1);

    $display("[TB] forced transfer of 0x00 after reset release");
    reset = 1'b0;
    captureTransfer("init_00", 8'h00, 68, 4, 8, -1, 8'h00, -1, 8'h00, -1, 8'h00);
    quietCheck("init_quiet", 40);

    $display("[TB] held word 0xA5");
    applyStimulus(8'hA5);
    captureTransfer("word_A5", 8'hA5, 68, 4, 8, -1, 8'h00, -1, 8'h00, -1, 8'h00);

    $display("[TB] 0x3C changed to 0xC3 mid-transfer");
    applyStimulus(8'h3C);
    captureTransfer("hold_3C", 8'h3C, 68, 4, 8, 20, 8'hC3, -1, 8'h00, -1, 8'h00);
    captureTransfer("next_C3", 8'hC3, 68, 4, 8, -1, 8'h00, -1, 8'h00, -1, 8'h00);

    $display("[TB] toggling 0x01/0x02/0x03 during a transfer");
    applyStimulus(8'h55);
    captureTransfer("hold_55", 8'h55, 68, 4, 8, 10, 8'h01, 30, 8'h02, 50, 8'h03);
    captureTransfer("final_03", 8'h03, 68, 4, 8, -1, 8'h00, -1, 8'h00, -1, 8'h00);
    checkOutput("last_sent_03", 32'(dut0.last_sent), 32'h03);
    quietCheck("final_quiet", 40);

    $display("[TB] reset at cycle 30 of a 0xFF transfer");
    applyStimulus(8'hFF);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!busy0 && k < 20);
    checkOutput("abort_start_delay", 32'(k), 32'd1);
    repeat (29) @(negedge clk);
    checkOutput("abort_pre_state", 32'({busy0, sr_data0, sr_latch0}), 32'b110);
    #1 reset = 1'b1;
    #1;
    checkOutput("abort_outputs", 32'({sr_clk0, sr_data0, sr_latch0, busy0}), 32'd0);
    checkOutput("abort_pending", 32'(dut0.pending), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    captureTransfer("after_abort_FF", 8'hFF, 68, 4, 8, -1, 8'h00, -1, 8'h00, -1, 8'h00);

    $display("[TB] CLK_DIV=1 instance with 0x80");
    sel = 1'b1;
    repeat (30) @(negedge clk);
    applyStimulus(8'h80);
    captureTransfer("div1_80", 8'h80, 17, 1, 2, -1, 8'h00, -1, 8'h00, -1, 8'h00);
    quietCheck("div1_quiet", 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
